// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: boot/run/halt/single-step sequencer for the single-cycle processor.
// Optional watchdog (RUN -> TIMEOUT after MAX_CYCLES) is built only when PROC_RUN_WATCHDOG_EN is defined.
module proc_run_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int BOOT_WORDS = 64,
  parameter int RST_HOLD   = 2,
  parameter int MAX_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              boot_valid,
  input  logic [DATA_W-1:0] boot_data,
  output logic              boot_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst,
  output logic              core_clk_en,
  input  logic              halt_in,
  input  logic              step_mode,
  input  logic              step_req,
  output logic [31:0]       cycle_count,
  output logic              done,
  output logic              timeout,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    HOLD    = 3'd2,
    RUN     = 3'd3,
    HALTED  = 3'd4,
    TIMEOUT = 3'd5
  } state_t;

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(BOOT_WORDS - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(RST_HOLD - 1);

  if (BOOT_WORDS < 1 || BOOT_WORDS > 2**ADDR_W || RST_HOLD < 1 || MAX_CYCLES < 1) begin : g_param_check
    $error("proc_run_ctrl: illegal parameter combination");
  end

  state_t            cur_st, nxt_st;
  logic [ADDR_W-1:0] load_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              step_pend;
  logic              accept, halt_q, wd_hit, boot_go;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign boot_ready  = (cur_st == LOAD);
  assign accept      = boot_valid & boot_ready;
  assign core_clk_en = (cur_st == RUN) && (!step_mode || step_pend);
  assign halt_q      = halt_in & core_clk_en;
  // Core stays out of reset once running so its state remains observable after a stop.
  assign core_rst    = !(cur_st == RUN || cur_st == HALTED || cur_st == TIMEOUT);
  assign done        = (cur_st == HALTED);
  assign state       = cur_st;
  assign boot_go     = start && (cur_st == IDLE || cur_st == HALTED || cur_st == TIMEOUT);

`ifdef PROC_RUN_WATCHDOG_EN
  // Fires on the enabled cycle that brings cycle_count up to MAX_CYCLES.
  assign wd_hit  = core_clk_en && (cycle_count >= 32'(MAX_CYCLES - 1));
  assign timeout = (cur_st == TIMEOUT);
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    nxt_st = cur_st;
    unique case (cur_st)
      IDLE, HALTED, TIMEOUT: if (start) nxt_st = LOAD;
      LOAD:    if (accept && load_idx == LAST_IDX) nxt_st = HOLD;
      HOLD:    if (hold_cnt == LAST_HOLD) nxt_st = RUN;
      RUN: begin
        if (halt_q)      nxt_st = HALTED;
        else if (wd_hit) nxt_st = TIMEOUT;
      end
      default: nxt_st = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_st      <= IDLE;
      load_idx    <= '0;
      hold_cnt    <= '0;
      step_pend   <= 1'b0;
      cycle_count <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
    end else begin
      cur_st  <= nxt_st;
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= load_idx;
        imem_wdata <= boot_data;
        load_idx   <= load_idx + ADDR_W'(1);
      end
      if (boot_go) begin
        load_idx    <= '0;
        cycle_count <= '0;
      end else if (core_clk_en) begin
        cycle_count <= sat_inc(cycle_count);
      end
      hold_cnt  <= (cur_st == HOLD) ? hold_cnt + HOLD_W'(1) : '0;
      // A request landing while one is pending is consumed by that pending step.
      step_pend <= (cur_st == RUN) && step_mode && step_req && !step_pend;
    end
  end

endmodule
